// File: rtl/typing_session_timer_pkg.sv
// Shared definitions for the typing session timer.
// Contents:
//   SYS_CLK_HZ    - system clock rate, the default counted-second length
//   TIME_W        - width of the seconds fields
//   timer_state_t - session FSM state encoding (3 bits)
package typing_pkg;

  localparam int SYS_CLK_HZ = 100_000_000;
  localparam int TIME_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_RUNNING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_DONE    = 3'd4
  } timer_state_t;

endpackage

// File: rtl/typing_session_timer_if.sv
// Session-control bundle between the keyboard/score logic and the timer.
// Optional feature macro: TIMER_PAUSE_EN (adds the pause strobe).
// Signals:
//   limit_sec, arm, key_strobe, abort, [pause] - requests into the timer
//   remaining, elapsed, running, finished, done, state - timer status
// Modports:
//   master - the requester (drives requests, observes status)
//   slave  - the timer
interface typing_session_timer_if #(
  parameter int TIME_W = typing_pkg::TIME_W
);

  logic [TIME_W-1:0] limit_sec;
  logic              arm;
  logic              key_strobe;
  logic              abort;
`ifdef TIMER_PAUSE_EN
  logic              pause;
`endif
  logic [TIME_W-1:0] remaining;
  logic [TIME_W-1:0] elapsed;
  logic              running;
  logic              finished;
  logic              done;
  logic [2:0]        state;

  modport master (
    output limit_sec, arm, key_strobe, abort,
`ifdef TIMER_PAUSE_EN
    output pause,
`endif
    input  remaining, elapsed, running, finished, done, state
  );

  modport slave (
    input  limit_sec, arm, key_strobe, abort,
`ifdef TIMER_PAUSE_EN
    input  pause,
`endif
    output remaining, elapsed, running, finished, done, state
  );

endinterface

// File: rtl/typing_session_timer_tick_prescaler.sv
// Restartable modulo-DIV counter producing a one-cycle tick.
// Ports:
//   clk, rst (sync, active-high)
//   clear  - restart the count at 0 (wins over enable)
//   enable - advance the count; while low the count is frozen
//   tick   - high in the enabled cycle where the count sits at DIV-1
// Parameter: DIV - cycles per tick.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int                CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = enable && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/typing_session_timer.sv
// Typing-test session controller: arm, wait for first key, count down the
// time limit in whole seconds, finish.
// Optional feature macro: TIMER_PAUSE_EN (pause/resume with the partial
// second preserved).
// Ports:
//   clk, rst (sync, active-high)
//   bus - typing_session_timer_if.slave (requests in, remaining/elapsed/
//         running/finished/done/state out)
// Parameters: TICK_DIV - clk cycles per counted second; TIME_W - seconds width.
//
// state   | meaning
// IDLE    | no session, counters cleared
// ARMED   | limit loaded, waiting for the first keystroke
// RUNNING | prescaler enabled, counting seconds
// PAUSED  | prescaler frozen mid-second (pause build only)
// DONE    | limit reached, remaining=0, elapsed=limit
module typing_session_timer #(
  parameter int TICK_DIV = typing_pkg::SYS_CLK_HZ,
  parameter int TIME_W   = typing_pkg::TIME_W
) (
  input logic                   clk,
  input logic                   rst,
  typing_session_timer_if.slave bus
);

  import typing_pkg::*;

  timer_state_t      r_state;
  logic [TIME_W-1:0] r_remaining;
  logic [TIME_W-1:0] r_elapsed;
  logic              r_running;
  logic              r_finished;
  logic              r_done;

  logic w_tick;
  logic w_clear;
  logic w_enable;
  logic w_pause;

`ifdef TIMER_PAUSE_EN
  assign w_pause = bus.pause;
`else
  assign w_pause = 1'b0;
`endif

  // The first second starts the cycle running rises, so the count is
  // restarted on the ARMED->RUNNING edge; abort also discards any partial second.
  assign w_enable = (r_state == ST_RUNNING);
  assign w_clear  = bus.abort || ((r_state == ST_ARMED) && bus.key_strobe);

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_clear),
    .enable (w_enable),
    .tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_elapsed   <= '0;
      r_running   <= 1'b0;
      r_finished  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        r_state     <= ST_IDLE;
        r_remaining <= '0;
        r_elapsed   <= '0;
        r_running   <= 1'b0;
        r_finished  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (bus.arm && (bus.limit_sec != '0)) begin
              r_state     <= ST_ARMED;
              r_remaining <= bus.limit_sec;
              r_elapsed   <= '0;
              r_finished  <= 1'b0;
            end
          end
          ST_ARMED: begin
            if (bus.key_strobe) begin
              r_state   <= ST_RUNNING;
              r_running <= 1'b1;
            end
          end
          ST_RUNNING: begin
            // A tick coinciding with pause is applied before pausing; the
            // final tick goes to DONE and the pause is dropped.
            if (w_tick) begin
              r_remaining <= r_remaining - TIME_W'(1);
              r_elapsed   <= r_elapsed + TIME_W'(1);
              if (r_remaining == TIME_W'(1)) begin
                r_state    <= ST_DONE;
                r_running  <= 1'b0;
                r_finished <= 1'b1;
                r_done     <= 1'b1;
              end else if (w_pause) begin
                r_state   <= ST_PAUSED;
                r_running <= 1'b0;
              end
            end else if (w_pause) begin
              r_state   <= ST_PAUSED;
              r_running <= 1'b0;
            end
          end
          ST_PAUSED: begin
            if (w_pause) begin
              r_state   <= ST_RUNNING;
              r_running <= 1'b1;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.remaining = r_remaining;
  assign bus.elapsed   = r_elapsed;
  assign bus.running   = r_running;
  assign bus.finished  = r_finished;
  assign bus.done      = r_done;
  assign bus.state     = r_state;

endmodule
